// File: rtl/ecall_display_ctrl_pkg.sv
// Shared types and constants for the print-integer display controller.
package ecall_display_ctrl_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIGITS = 8;
  localparam int BCD_W  = 40;  // ten BCD digits cover the full 32-bit magnitude

  // Active-high segment code with every segment (and dp) off
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high glyph for a hex nibble, bit order {dp,g,f,e,d,c,b,a}
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] code;
    code = SEG_BLANK;
    case (nib)
      4'h0: code = 8'h3F;
      4'h1: code = 8'h06;
      4'h2: code = 8'h5B;
      4'h3: code = 8'h4F;
      4'h4: code = 8'h66;
      4'h5: code = 8'h6D;
      4'h6: code = 8'h7D;
      4'h7: code = 8'h07;
      4'h8: code = 8'h7F;
      4'h9: code = 8'h6F;
      4'hA: code = 8'h77;
      4'hB: code = 8'h7C;
      4'hC: code = 8'h39;
      4'hD: code = 8'h5E;
      4'hE: code = 8'h79;
      4'hF: code = 8'h71;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/ecall_display_ctrl_seg7_encoder.sv
// Nibble to active-high 7-segment code; blank forces all segments off.
module seg7_encoder
  import ecall_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  // Glyph lookup, decimal point never lit
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = glyph(nibble);
  end

endmodule

// File: rtl/ecall_display_ctrl.sv
// Print-integer ecall display: double-dabble BCD conversion of a0 and
// multiplexed 8-digit 7-segment scan with sign/overflow LEDs.
//
// Handshake: io_out is a level request, not a valid/ready pair. A conversion
// starts from IDLE whenever io_out is high and a0_data differs from the value
// currently shown; busy is high from the start edge until the commit edge, and
// a0_data is only re-sampled once the FSM is back in IDLE.
module ecall_display_ctrl
  import ecall_display_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_out,
  input  logic [31:0] a0_data,
  input  logic        hex_mode,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat,
  output logic        neg_led,
  output logic        ovf_led,
  output logic        busy
);

  localparam int DIV_RAW = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [7:0] POL = {8{SEG_ACT_LOW}};

  state_t            state;
  state_t            state_next;
  logic              start;
  logic [31:0]       shown_val;
  logic [31:0]       mag;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [5:0]        cnt;
  logic [31:0]       disp_bcd;
  logic              neg_q;
  logic              ovf_q;
  logic [PRE_W-1:0]  pre_cnt;
  logic [2:0]        digit_idx;
  logic [2:0]        digit_next;
  logic              scan_wrap;
  logic [31:0]       hex_sh;
  logic [31:0]       dec_sh;
  logic [3:0]        nib;
  logic              blank;
  logic [7:0]        seg_code;

  assign start   = (state == ST_IDLE) && io_out && (a0_data != shown_val);
  assign bcd_adj = dabble_adjust(bcd);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next state: 32 shifts in CONV, one commit cycle in DONE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_CONV;
      ST_CONV: if (cnt == 6'd31) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Conversion datapath and committed display registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown_val <= '0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      disp_bcd  <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shown_val <= a0_data;
            // 0x8000_0000 negates to itself, which is the correct unsigned magnitude
            mag       <= a0_data[31] ? (32'd0 - a0_data) : a0_data;
            bcd       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
          end
        end
        ST_CONV: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt + 6'd1;
        end
        ST_DONE: begin
          disp_bcd <= bcd[31:0];
          neg_q    <= shown_val[31];
          ovf_q    <= |bcd[BCD_W-1:32];
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign scan_wrap  = (pre_cnt == PRE_LAST);
  assign digit_next = digit_idx + 3'd1;

  // Scan prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt   <= '0;
      digit_idx <= '0;
    end else if (scan_wrap) begin
      pre_cnt   <= '0;
      digit_idx <= digit_next;
    end else begin
      pre_cnt   <= pre_cnt + PRE_W'(1);
    end
  end

  // Select the nibble for the digit about to be shown, with leading-zero blanking
  always_comb begin
    hex_sh = shown_val >> {digit_next, 2'b00};
    dec_sh = disp_bcd >> {digit_next, 2'b00};
    nib    = dec_sh[3:0];
    blank  = (digit_next != 3'd0) && (dec_sh == 32'd0);
    if (hex_mode) begin
      nib   = hex_sh[3:0];
      blank = 1'b0;
    end
  end

  seg7_encoder u_enc (
    .nibble (nib),
    .blank  (blank),
    .seg    (seg_code)
  );

  // Registered, polarity-adjusted anode and cathode outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_an  <= POL;
      seg_cat <= SEG_BLANK ^ POL;
    end else if (scan_wrap) begin
      seg_an  <= (8'b1 << digit_next) ^ POL;
      seg_cat <= seg_code ^ POL;
    end
  end

  assign neg_led = neg_q & ~hex_mode;
  assign ovf_led = ovf_q & ~hex_mode;

endmodule

// File: tb/tb_ecall_display_ctrl.sv
// Testbench for ecall_display_ctrl: table vectors, corner sequences and
// randomized values checked against a decimal/hex display model.
module tb_ecall_display_ctrl;

  localparam int CLK_HZ  = 1600;
  localparam int SCAN_HZ = 100;
  localparam int ROUND   = 16;        // 8 digits x 2 cycles per digit
  localparam logic [7:0] POL = 8'hFF; // active-low outputs

  logic        clk = 1'b0;
  logic        reset;
  logic        io_out;
  logic [31:0] a0_data;
  logic        hex_mode;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;
  logic        neg_led;
  logic        ovf_led;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_seg [8];
  logic       cap_seen [8];

  typedef struct {
    logic [31:0] val;
    logic        hex;
    logic [63:0] text;  // eight characters, leftmost is digit 7
    logic        neg;
    logic        ovf;
  } vec_t;
  vec_t vecs [9];

  // clock / reset
  always #5 clk = ~clk;

  ecall_display_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .SCAN_HZ     (SCAN_HZ),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_out   (io_out),
    .a0_data  (a0_data),
    .hex_mode (hex_mode),
    .seg_an   (seg_an),
    .seg_cat  (seg_cat),
    .neg_led  (neg_led),
    .ovf_led  (ovf_led),
    .busy     (busy)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_glyph(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    return t[n];
  endfunction

  function automatic logic [7:0] char_glyph(input logic [7:0] c);
    logic [7:0] d;
    if (c == 8'h20) return 8'h00;
    if (c >= 8'h41) d = c - 8'h41 + 8'd10;
    else            d = c - 8'h30;
    return ref_glyph(d[3:0]);
  endfunction

  function automatic longint ref_mag(input logic [31:0] v);
    longint m;
    m = longint'({32'd0, v});
    if (v[31]) m = 64'sd4294967296 - m;
    return m;
  endfunction

  // Display model: decimal digits of |v| with leading-zero blanking, or raw hex
  function automatic logic [7:0] model_glyph(input logic [31:0] v, input logic hex, input int k);
    logic [31:0] s;
    longint low, p, d;
    if (hex) begin
      s = v >> (4 * k);
      return ref_glyph(s[3:0]);
    end
    low = ref_mag(v) % 100000000;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && low < p) return 8'h00;
    d = (low / p) % 10;
    return ref_glyph(4'(d));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_text(input logic [63:0] text);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) begin
      c = text[8*k +: 8];
      exp_q.push_back(char_glyph(c));
    end
  endtask

  task automatic push_model(input logic [31:0] v, input logic hex);
    for (int k = 0; k < 8; k++) exp_q.push_back(model_glyph(v, hex, k));
  endtask

  // Record the most recent cathode pattern seen for each digit
  task automatic capture(input int ncyc);
    logic [7:0] an;
    int idx;
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) cap_seen[k] = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      an = seg_an ^ POL;
      if (an != 8'h00) begin
        if ($onehot(an)) begin
          idx = 0;
          for (int k = 0; k < 8; k++) if (an[k]) idx = k;
          cap_seg[idx]  = seg_cat ^ POL;
          cap_seen[idx] = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
    end
    check("anode_onehot", {31'd0, bad}, 32'd0);
  endtask

  task automatic compare_display(input string tag);
    logic [7:0] want;
    logic [31:0] got;
    for (int k = 0; k < 8; k++) begin
      want = exp_q.pop_front();
      got  = cap_seen[k] ? {24'd0, cap_seg[k]} : 32'h100;
      check($sformatf("%s digit%0d", tag, k), got, {24'd0, want});
    end
  endtask

  // Start a conversion and count cycles with busy high (bounded)
  task automatic run_conv(input logic [31:0] v, input logic hex, output int n);
    @(posedge clk);
    #1;
    a0_data  = v;
    hex_mode = hex;
    io_out   = 1'b1;
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask

  task automatic wait_busy(input logic level, input int limit);
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (busy == level) break;
    end
  endtask

  initial begin
    int n;
    logic [31:0] v, last;
    logic hex;

    vecs[0] = '{32'd12345,      1'b0, "   12345", 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFF9,  1'b0, "       7", 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000,  1'b0, "47483648", 1'b1, 1'b1};
    vecs[3] = '{32'hDEAD_BEEF,  1'b1, "DEADBEEF", 1'b0, 1'b0};
    vecs[4] = '{32'd100000000,  1'b0, "       0", 1'b0, 1'b1};
    vecs[5] = '{32'd99999999,   1'b0, "99999999", 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0010,  1'b1, "00000010", 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF,  1'b0, "       1", 1'b1, 1'b0};
    vecs[8] = '{32'h7FFF_FFFF,  1'b0, "47483647", 1'b0, 1'b1};

    reset = 1'b1; io_out = 1'b0; a0_data = 32'd0; hex_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset seg_an", {24'd0, seg_an}, {24'd0, POL});
    check("reset seg_cat", {24'd0, seg_cat}, {24'd0, POL});
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset neg", {31'd0, neg_led}, 32'd0);
    check("reset ovf", {31'd0, ovf_led}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    capture(2 * ROUND);
    push_text("       0");
    compare_display("idle_zero");
    check("idle busy", {31'd0, busy}, 32'd0);

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].val, vecs[i].hex, n);
      check($sformatf("vec%0d busy_cycles", i), n, 32'd33);
      check($sformatf("vec%0d neg", i), {31'd0, neg_led}, {31'd0, vecs[i].neg});
      check($sformatf("vec%0d ovf", i), {31'd0, ovf_led}, {31'd0, vecs[i].ovf});
      capture(2 * ROUND);
      push_text(vecs[i].text);
      compare_display($sformatf("vec%0d", i));
    end

    // a0 change during conversion is ignored, then picked up back-to-back
    @(posedge clk);
    #1;
    hex_mode = 1'b0; a0_data = 32'd5; io_out = 1'b1;
    wait_busy(1'b1, 10);
    check("chg busy_rise", {31'd0, busy}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    a0_data = 32'd9;
    wait_busy(1'b0, 100);
    check("chg first_done", {31'd0, busy}, 32'd0);
    check("chg neg", {31'd0, neg_led}, 32'd0);
    @(negedge clk);
    check("chg back_to_back", {31'd0, busy}, 32'd1);
    capture(ROUND + 2);
    push_text("       5");
    compare_display("chg_first");
    wait_busy(1'b0, 100);
    check("chg second_done", {31'd0, busy}, 32'd0);
    capture(2 * ROUND);
    push_text("       9");
    compare_display("chg_second");

    // reset during conversion aborts without committing
    @(posedge clk);
    #1;
    a0_data = 32'hFFFF_FC19;
    wait_busy(1'b1, 10);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort seg_an", {24'd0, seg_an}, {24'd0, POL});
    check("abort seg_cat", {24'd0, seg_cat}, {24'd0, POL});
    check("abort neg", {31'd0, neg_led}, 32'd0);
    check("abort ovf", {31'd0, ovf_led}, 32'd0);
    io_out = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    capture(2 * ROUND);
    push_text("       0");
    compare_display("abort");
    check("abort busy_after", {31'd0, busy}, 32'd0);

    // randomized values against the display model
    last = 32'd0;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 999);
        1:       v = 32'd0 - $urandom_range(1, 99999);
        2:       v = $urandom;
        default: v = 32'd99999990 + $urandom_range(0, 20);
      endcase
      if (v == last) v = v ^ 32'd1;
      hex = ($urandom_range(0, 3) == 0);
      run_conv(v, hex, n);
      check($sformatf("rnd%0d busy_cycles", i), n, 32'd33);
      check($sformatf("rnd%0d neg", i), {31'd0, neg_led}, {31'd0, !hex && v[31]});
      check($sformatf("rnd%0d ovf", i), {31'd0, ovf_led},
            {31'd0, !hex && (ref_mag(v) > 64'sd99999999)});
      capture(2 * ROUND);
      push_model(v, hex);
      compare_display($sformatf("rnd%0d v=%0h", i, v));
      last = v;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
